mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_pkg.sv | 6 +
 rtl/mult_shift_add_core.sv | 40 ++++
 rtl/mult_sched.sv | 94 +++++++++
 tb/tb_mult_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and datapath widths for the mult_sched slice.
package mult_pkg;
    localparam int OP_W  = 8;
    localparam int RES_W = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mult_shift_add_core.sv
// mult_shift_add_core: serial shift-add multiplier, one bit of y per cycle, LSB first.
module mult_shift_add_core
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [OP_W-1:0]  i_x,
    input  logic [OP_W-1:0]  i_y,
    output logic             o_done,
    output logic [RES_W-1:0] o_res
);
    logic [RES_W-1:0] r_x;
    logic [RES_W-1:0] r_acc;
    logic [OP_W-1:0]  r_y;
    logic [3:0]       r_cnt;

    // Counter parks at OP_W so the core reads as done until the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
            r_cnt <= 4'(OP_W);
        end else if (i_start) begin
            r_x   <= RES_W'(i_x);
            r_y   <= i_y;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (!o_done) begin
            r_acc <= r_acc + (r_y[0] ? r_x : '0);
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_done = r_cnt == 4'(OP_W);
    assign o_res  = r_acc;
endmodule

// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler sharing one serial multiplier among NUM_REQ requesters.
// Define MULT_SCHED_ZERO_SKIP_EN to short-cut requests with a zero operand.
module mult_sched
    import mult_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [OP_W*NUM_REQ-1:0] req_x,
    input  logic [OP_W*NUM_REQ-1:0] req_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IW-1:0]           rsp_id,
    output logic [RES_W-1:0]        rsp_res,
    output logic                    busy
);
    state_t           r_state, w_next;
    logic [IW-1:0]    r_ptr, r_id, w_gnt, w_idx;
    logic             w_gnt_vld, w_accept, w_zero_op, r_zero, w_core_done;
    logic [OP_W-1:0]  w_x, w_y;
    logic [RES_W-1:0] r_res, w_core_res;

    // Scan downward so the requester closest to r_ptr is assigned last and wins.
    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        w_idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_gnt     = w_idx;
                w_gnt_vld = 1'b1;
            end
        end
    end

    assign w_accept  = r_state == IDLE && w_gnt_vld && !reset;
    assign req_ready = w_accept ? NUM_REQ'(1) << w_gnt : '0;
    assign w_x       = req_x[w_gnt*OP_W +: OP_W];
    assign w_y       = req_y[w_gnt*OP_W +: OP_W];
`ifdef MULT_SCHED_ZERO_SKIP_EN
    assign w_zero_op = w_x == '0 || w_y == '0;
`else
    assign w_zero_op = 1'b0;
`endif

    mult_shift_add_core u_core (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_accept),
        .i_x     (w_x),
        .i_y     (w_y),
        .o_done  (w_core_done),
        .o_res   (w_core_res)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = (w_core_done || r_zero) ? DONE : RUN;
            DONE:    w_next = rsp_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_zero  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ptr  <= IW'((int'(w_gnt) + 1) % NUM_REQ);
                r_id   <= w_gnt;
                r_zero <= w_zero_op;
            end
            if (r_state == RUN && w_next == DONE)
                r_res <= r_zero ? '0 : w_core_res;
        end
    end

    assign rsp_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign rsp_id    = r_id;
    assign rsp_res   = r_res;
endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: randomized self-checking bench for mult_sched against a round-robin/product model.
module tb_mult_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_res;
    logic        busy;
    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    mult_sched #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .busy      (busy)
    );

    function automatic int model_grant(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic int exp_lat(input int x, input int y);
`ifdef MULT_SCHED_ZERO_SKIP_EN
        return (x == 0 || y == 0) ? 1 : 9;
`else
        return 9;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
    endtask

    // Drives one transaction from a negedge and reports what the DUT did; lat counts edges after acceptance.
    task automatic txn(input logic [3:0] mask, input bit keep, input logic [31:0] xs, input logic [31:0] ys,
                       input int stall, input bit noise, output int gid, output int rid, output int res,
                       output int lat, output bit stable, output bit rdy_low, output bit onehot);
        gid = -1; rid = -1; res = -1; lat = -1; stable = 1; rdy_low = 1; onehot = 0;
        req_valid = mask;
        req_x = xs;
        req_y = ys;
        for (int i = 0; i < 20 && gid < 0; i++) begin
            #1;
            if (|req_ready) begin
                onehot = $onehot(req_ready);
                for (int k = 0; k < 4; k++) if (req_ready[k]) gid = k;
            end else @(negedge clk);
        end
        if (gid < 0) return;
        @(posedge clk);
        #1 if (!keep) req_valid = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
            rsp_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        rsp_ready = 1'b0;
        if (lat < 0) return;
        res = int'(rsp_res);
        rid = int'(rsp_id);
        if (stall > 0) req_valid = 4'hF;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!rsp_valid || int'(rsp_res) != res || int'(rsp_id) != rid) stable = 0;
            if (req_ready !== 4'b0) rdy_low = 0;
        end
        req_valid = keep ? mask : 4'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_res !== 16'd0) begin errors++; $display("FAIL reset_rsp_res: got %0d expected 0", rsp_res); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        req_valid = '0;
        rsp_ready = 1'b0;
        reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        int gid, rid, res, lat; bit st, rl, oh;
        do_reset();
        txn(4'b0001, 0, 32'd13, 32'd11, 0, 0, gid, rid, res, lat, st, rl, oh);
        m_ptr = 1;
        checks++; if (gid != 0) begin errors++; $display("FAIL single_grant: got %0d expected 0", gid); end
        checks++; if (rid != 0) begin errors++; $display("FAIL single_rsp_id: got %0d expected 0", rid); end
        checks++; if (res != 143) begin errors++; $display("FAIL single_res: got %0d expected 143", res); end
        checks++; if (lat != 9) begin errors++; $display("FAIL single_latency: got %0d expected 9", lat); end
        checks++; if (!oh) begin errors++; $display("FAIL single_onehot: got 0 expected 1"); end
    endtask

    task automatic test_round_robin();
        int gid, rid, res, lat, eg; bit st, rl, oh;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            eg = model_grant(4'hF, m_ptr);
            txn(4'hF, 1, {8'd2, 8'd2, 8'd2, 8'd2}, {8'd4, 8'd3, 8'd2, 8'd1}, 0, 0, gid, rid, res, lat, st, rl, oh);
            m_ptr = (eg + 1) % 4;
            checks++; if (gid != eg || rid != eg) begin errors++; $display("FAIL rr_grant[%0d]: got %0d/%0d expected %0d", i, gid, rid, eg); end
            checks++; if (res != 2 * (eg + 1)) begin errors++; $display("FAIL rr_res[%0d]: got %0d expected %0d", i, res, 2 * (eg + 1)); end
            checks++; if (!oh) begin errors++; $display("FAIL rr_onehot[%0d]: got 0 expected 1", i); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int gid, rid, res, lat; bit st, rl, oh;
        do_reset();
        txn(4'b0010, 0, 32'h0000_FF00, 32'h0000_FF00, 5, 0, gid, rid, res, lat, st, rl, oh);
        m_ptr = 2;
        checks++; if (gid != 1 || rid != 1) begin errors++; $display("FAIL bp_grant: got %0d/%0d expected 1", gid, rid); end
        checks++; if (res != 65025) begin errors++; $display("FAIL bp_res: got %0d expected 65025", res); end
        checks++; if (!st) begin errors++; $display("FAIL bp_stable: got 0 expected 1"); end
        checks++; if (!rl) begin errors++; $display("FAIL bp_ready_low: got 0 expected 1"); end
    endtask

    task automatic test_reset_mid_run();
        int gid, rid, res, lat, bad; bit st, rl, oh;
        do_reset();
        req_valid = 4'b0001;
        req_x = 32'd100;
        req_y = 32'd3;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_async: got busy=%b valid=%b expected 0/0", busy, rsp_valid); end
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_rsp: got %0d valid cycles expected 0", bad); end
        txn(4'b0100, 0, 32'h0007_0000, 32'h0009_0000, 0, 0, gid, rid, res, lat, st, rl, oh);
        checks++; if (gid != 2 || res != 63) begin errors++; $display("FAIL mid_next: got id %0d res %0d expected 2/63", gid, res); end
        do_reset();
        req_valid = 4'b0010;
        req_x = 32'h0000_6400;
        req_y = 32'h0000_0300;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);
        do_reset();
        txn(4'b0110, 0, 32'h0005_0600, 32'h0003_0700, 0, 0, gid, rid, res, lat, st, rl, oh);
        checks++; if (gid != 1 || res != 42) begin errors++; $display("FAIL mid_ptr_cleared: got id %0d res %0d expected 1/42", gid, res); end
    endtask

    task automatic test_zero();
        int gid, rid, res, lat; bit st, rl, oh;
        do_reset();
        txn(4'b0001, 0, 32'd0, 32'd200, 0, 0, gid, rid, res, lat, st, rl, oh);
        checks++; if (res != 0) begin errors++; $display("FAIL zero_x_res: got %0d expected 0", res); end
        checks++; if (lat != exp_lat(0, 200)) begin errors++; $display("FAIL zero_x_latency: got %0d expected %0d", lat, exp_lat(0, 200)); end
        txn(4'b1000, 0, 32'h4D00_0000, 32'd0, 0, 0, gid, rid, res, lat, st, rl, oh);
        checks++; if (gid != 3 || res != 0) begin errors++; $display("FAIL zero_y_res: got id %0d res %0d expected 3/0", gid, res); end
        checks++; if (lat != exp_lat(77, 0)) begin errors++; $display("FAIL zero_y_latency: got %0d expected %0d", lat, exp_lat(77, 0)); end
    endtask

    task automatic test_random();
        int gid, rid, res, lat, eg, ex, ey, stall; bit st, rl, oh, keep;
        logic [3:0] mask; logic [31:0] xs, ys;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            mask = 4'($urandom_range(1, 15));
            xs = $urandom;
            ys = $urandom;
            if (i % 5 == 0) xs = xs & 32'h00FF_00FF;
            stall = $urandom_range(0, 3);
            keep = 1'($urandom_range(0, 1));
            eg = model_grant(mask, m_ptr);
            ex = int'(xs[eg*8 +: 8]);
            ey = int'(ys[eg*8 +: 8]);
            txn(mask, keep, xs, ys, stall, 1, gid, rid, res, lat, st, rl, oh);
            m_ptr = (eg + 1) % 4;
            checks++; if (gid != eg || rid != eg) begin errors++; $display("FAIL rand_grant[%0d]: got %0d/%0d expected %0d", i, gid, rid, eg); end
            checks++; if (res != ex * ey) begin errors++; $display("FAIL rand_res[%0d]: got %0d expected %0d", i, res, ex * ey); end
            checks++; if (lat != exp_lat(ex, ey)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(ex, ey)); end
            checks++; if (!st || !rl || !oh) begin errors++; $display("FAIL rand_hold[%0d]: got stable=%b ready_low=%b onehot=%b expected 1/1/1", i, st, rl, oh); end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        test_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
